// File: rtl/video_timing_generator.sv
// Single-clock raster timing generator: h/v counters with registered decode of
// sync, active, data-enable, pixel coordinates and line/frame start pulses.
module video_timing_generator #(
  parameter int   H_ACTIVE  = 1920,
  parameter int   H_FRONT   = 88,
  parameter int   H_SYNC    = 44,
  parameter int   H_BACK    = 148,
  parameter int   V_ACTIVE  = 1080,
  parameter int   V_FRONT   = 4,
  parameter int   V_SYNC    = 5,
  parameter int   V_BACK    = 36,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  localparam int  H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  HW        = $clog2(H_TOTAL),
  localparam int  VW        = $clog2(V_TOTAL),
  localparam int  XW        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int  YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          hactive,
  output logic          vactive,
  output logic          dena,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_size
    $error("video_timing_generator: every size parameter must be at least 1");
  end

  // Region boundaries; every value is below the total, so it fits the counter width.
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEGIN = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEGIN = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_in_act, v_in_act, h_in_sync, v_in_sync;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign h_in_act  = (h_cnt < H_ACT_END);
  assign v_in_act  = (v_cnt < V_ACT_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEGIN) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEGIN) && (v_cnt < V_SYNC_END);

  // Outputs decode the pre-edge counter value, so every output describes the same
  // pixel one cycle after the counters reached it.
  // NOTE: reset is sampled inside the clocked block (synchronous), and all state
  // uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hactive     <= 1'b0;
      vactive     <= 1'b0;
      dena        <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      hactive     <= h_in_act;
      vactive     <= v_in_act;
      dena        <= h_in_act && v_in_act;
      x           <= h_in_act ? h_cnt[XW-1:0] : '0;
      y           <= v_in_act ? v_cnt[YW-1:0] : '0;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Held cycles keep the raster frozen but must not stretch a pulse.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: linear-pixel-index reference model compared every
// cycle on three builds (small, small inverted-polarity, 1080p), plus directed checks.
module tb_video_timing_generator;

  logic clk = 1'b0;
  logic reset, enable;

  logic s_hsync, s_vsync, s_hactive, s_vactive, s_dena, s_ls, s_fs;
  logic [2:0] s_x;
  logic [1:0] s_y;
  logic i_hsync, i_vsync, i_hactive, i_vactive, i_dena, i_ls, i_fs;
  logic [2:0] i_x;
  logic [1:0] i_y;
  logic f_hsync, f_vsync, f_hactive, f_vactive, f_dena, f_ls, f_fs;
  logic [10:0] f_x;
  logic [10:0] f_y;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  video_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_small (
    .pixel_clk(clk), .reset(reset), .enable(enable),
    .hsync(s_hsync), .vsync(s_vsync), .hactive(s_hactive), .vactive(s_vactive),
    .dena(s_dena), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_inv (
    .pixel_clk(clk), .reset(reset), .enable(enable),
    .hsync(i_hsync), .vsync(i_vsync), .hactive(i_hactive), .vactive(i_vactive),
    .dena(i_dena), .x(i_x), .y(i_y), .line_start(i_ls), .frame_start(i_fs)
  );

  video_timing_generator u_full (
    .pixel_clk(clk), .reset(reset), .enable(enable),
    .hsync(f_hsync), .vsync(f_vsync), .hactive(f_hactive), .vactive(f_vactive),
    .dena(f_dena), .x(f_x), .y(f_y), .line_start(f_ls), .frame_start(f_fs)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Output vector: {hsync, vsync, hactive, vactive, dena, line_start, frame_start, x[15:0], y[15:0]}
  function automatic logic [38:0] decode(input int p, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input bit hp, input bit vp);
    int  ht, h, v;
    bit  hsy, vsy, hi, vi;
    ht  = ha + hf + hs + hb;
    h   = p % ht;
    v   = p / ht;
    hsy = (h >= ha + hf) && (h < ha + hf + hs);
    vsy = (v >= va + vf) && (v < va + vf + vs);
    hi  = (h < ha);
    vi  = (v < va);
    return {hp ? hsy : !hsy, vp ? vsy : !vsy, hi, vi, hi && vi, h == 0, p == 0,
            16'(hi ? h : 0), 16'(vi ? v : 0)};
  endfunction

  function automatic logic [38:0] rst_vec(input bit hp, input bit vp);
    return {!hp, !vp, 37'd0};
  endfunction

  // Reference model: a linear pixel index per frame; expected outputs are the decode
  // of the index held before each enabled edge.
  int          ps = 0;
  int          pf = 0;
  logic [38:0] exp_s, exp_i, exp_f;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      exp_s  <= rst_vec(1'b1, 1'b1);
      exp_i  <= rst_vec(1'b0, 1'b0);
      exp_f  <= rst_vec(1'b1, 1'b1);
      ps     <= 0;
      pf     <= 0;
      chk_en <= 1'b1;
    end else if (enable) begin
      exp_s <= decode(ps, 8, 2, 3, 3, 4, 1, 2, 1'b1, 1'b1);
      exp_i <= decode(ps, 8, 2, 3, 3, 4, 1, 2, 1'b0, 1'b0);
      exp_f <= decode(pf, 1920, 88, 44, 148, 1080, 4, 5, 1'b1, 1'b1);
      ps    <= (ps + 1) % 128;
      pf    <= (pf + 1) % (2200 * 1125);
    end else begin
      exp_s[33:32] <= 2'b00;
      exp_i[33:32] <= 2'b00;
      exp_f[33:32] <= 2'b00;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_small", 64'({s_hsync, s_vsync, s_hactive, s_vactive, s_dena, s_ls, s_fs,
                                16'(s_x), 16'(s_y)}), 64'(exp_s));
      check("model_inv", 64'({i_hsync, i_vsync, i_hactive, i_vactive, i_dena, i_ls, i_fs,
                              16'(i_x), 16'(i_y)}), 64'(exp_i));
      check("model_full", 64'({f_hsync, f_vsync, f_hactive, f_vactive, f_dena, f_ls, f_fs,
                               16'(f_x), 16'(f_y)}), 64'(exp_f));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dena_cnt, vs_cnt, ls_cnt, vs_rise, inv_vs_low, per, f_dena_cnt;
    bit prev_vs;

    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", 64'(s_hsync), 64'd0);
    check("rst_vsync", 64'(s_vsync), 64'd0);
    check("rst_dena", 64'(s_dena), 64'd0);
    check("rst_x", 64'(s_x), 64'd0);
    check("rst_frame_start", 64'(s_fs), 64'd0);
    check("rst_inv_hsync", 64'(i_hsync), 64'd1);
    check("rst_inv_vsync", 64'(i_vsync), 64'd1);

    // First frame of the small raster.
    reset      = 1'b1;
    enable     = 1'b1;
    dena_cnt   = 0;
    vs_cnt     = 0;
    ls_cnt     = 0;
    vs_rise    = -1;
    inv_vs_low = 0;
    prev_vs    = 1'b0;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("first_frame_start", 64'(s_fs), 64'd1);
        check("first_line_start", 64'(s_ls), 64'd1);
        check("first_dena", 64'(s_dena), 64'd1);
        check("first_x", 64'(s_x), 64'd0);
        check("first_y", 64'(s_y), 64'd0);
      end
      if (n >= 1 && n <= 7) check("x_count", 64'(s_x), 64'(n));
      if (n == 8) check("hactive_fall", 64'(s_hactive), 64'd0);
      if (n >= 9 && n <= 13) begin
        check("hsync_window", 64'(s_hsync), 64'((n >= 10) && (n <= 12)));
        check("inv_hsync_window", 64'(i_hsync), 64'(!((n >= 10) && (n <= 12))));
      end
      if (n == 16) begin
        check("line1_start", 64'(s_ls), 64'd1);
        check("line1_y", 64'(s_y), 64'd1);
      end
      if (n == 48) check("vactive_line3", 64'(s_vactive), 64'd1);
      if (n == 64) check("vactive_line4", 64'(s_vactive), 64'd0);
      dena_cnt += int'(s_dena);
      vs_cnt   += int'(s_vsync);
      ls_cnt   += int'(s_ls);
      if (!i_vsync) inv_vs_low++;
      if (s_vsync && !prev_vs) begin
        vs_rise = n;
        check("vsync_rise_with_line_start", 64'(s_ls), 64'd1);
      end
      prev_vs = s_vsync;
    end
    check("dena_per_frame", 64'(dena_cnt), 64'd32);
    check("vsync_cycles", 64'(vs_cnt), 64'd32);
    check("line_starts", 64'(ls_cnt), 64'd8);
    check("vsync_rise_cycle", 64'(vs_rise), 64'd80);
    check("inv_vsync_low_cycles", 64'(inv_vs_low), 64'd32);

    // Second frame: hold for 5 cycles at x=4, frame stretches to 133 cycles.
    @(negedge clk);
    check("frame2_start", 64'(s_fs), 64'd1);
    repeat (4) @(negedge clk);
    check("pre_hold_x", 64'(s_x), 64'd4);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_x", 64'(s_x), 64'd4);
      check("hold_line_start", 64'(s_ls), 64'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_x", 64'(s_x), 64'd5);
    per = 10;
    while (per < 300 && !s_fs) begin
      @(negedge clk);
      per++;
    end
    check("frame_period_with_hold", 64'(per), 64'd133);

    // Reset mid-frame at line 6, h=11 (inside both sync regions).
    repeat (107) @(negedge clk);
    check("pre_reset_vsync", 64'(s_vsync), 64'd1);
    check("pre_reset_hsync", 64'(s_hsync), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_hsync", 64'(s_hsync), 64'd0);
    check("midrst_vsync", 64'(s_vsync), 64'd0);
    check("midrst_hactive", 64'(s_hactive), 64'd0);
    check("midrst_dena", 64'(s_dena), 64'd0);
    check("midrst_x", 64'(s_x), 64'd0);
    check("midrst_line_start", 64'(s_ls), 64'd0);
    check("midrst_inv_vsync", 64'(i_vsync), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("restart_frame_start", 64'(s_fs), 64'd1);
    check("restart_dena", 64'(s_dena), 64'd1);
    check("restart_x", 64'(s_x), 64'd0);
    check("restart_y", 64'(s_y), 64'd0);
    check("full_frame_start", 64'(f_fs), 64'd1);

    // First line of the 1080p build.
    f_dena_cnt = int'(f_dena);
    for (int n = 1; n <= 2200; n++) begin
      @(negedge clk);
      if (n < 2200) f_dena_cnt += int'(f_dena);
      if (n == 1919) begin
        check("full_hactive_last", 64'(f_hactive), 64'd1);
        check("full_x_last", 64'(f_x), 64'd1919);
      end
      if (n == 1920) check("full_hactive_fall", 64'(f_hactive), 64'd0);
      if (n == 2007) check("full_hsync_before", 64'(f_hsync), 64'd0);
      if (n == 2008) check("full_hsync_rise", 64'(f_hsync), 64'd1);
      if (n == 2051) check("full_hsync_last", 64'(f_hsync), 64'd1);
      if (n == 2052) check("full_hsync_fall", 64'(f_hsync), 64'd0);
      if (n == 2200) begin
        check("full_line1_start", 64'(f_ls), 64'd1);
        check("full_line1_y", 64'(f_y), 64'd1);
      end
    end
    check("full_dena_line0", 64'(f_dena_cnt), 64'd1920);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Parametrised, single-clock raster timing generator for the display path; drives sync, active and data-enable strobes plus pixel coordinates to the pixel renderer and video output stage.
- Successor to the current fixed-threshold timing controller: explicit porch/sync/back-porch sizing, programmable sync polarity, and a single clock domain (vertical logic advanced by a line-wrap strobe, never clocked from hsync).
- Adds x/y coordinates, line/frame start pulses and a run/hold enable.

Parameters:
- H_ACTIVE, 1920, visible pixels per line
- H_FRONT, 88, horizontal front porch, in pixels
- H_SYNC, 44, hsync pulse width, in pixels
- H_BACK, 148, horizontal back porch, in pixels
- V_ACTIVE, 1080, visible lines per frame
- V_FRONT, 4, vertical front porch, in lines
- V_SYNC, 5, vsync pulse width, in lines
- V_BACK, 36, vertical back porch, in lines
- HSYNC_POL, 1, asserted level of hsync (1 = active-high)
- VSYNC_POL, 1, asserted level of vsync
- Derived values:
  - H_TOTAL = sum of the H sizes; V_TOTAL = sum of the V sizes.
  - HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL).
  - XW = $clog2(H_ACTIVE), YW = $clog2(V_ACTIVE).
- Every size parameter must be ≥ 1. Elaboration fails otherwise.

Ports:
- pixel_clk, input, 1, pixel clock; the only clock
- reset, input, 1, synchronous active-low reset
- enable, input, 1, 1 = raster advances; 0 = counters and outputs hold
- hsync, output, 1, horizontal sync at HSYNC_POL level during the sync region
- vsync, output, 1, vertical sync at VSYNC_POL level during the sync lines
- hactive, output, 1, horizontal active region
- vactive, output, 1, vertical active region
- dena, output, 1, hactive AND vactive
- x, output, XW, pixel column inside the active region; 0 elsewhere
- y, output, YW, active line index; 0 outside vactive
- line_start, output, 1, one-cycle pulse at h position 0
- frame_start, output, 1, one-cycle pulse at h position 0, v position 0

Behaviour:
- Internal counters:
  - h_cnt (HW bits) counts 0..H_TOTAL-1.
  - v_cnt (VW bits) counts 0..V_TOTAL-1.
  - Both are in pixel_clk domain only.
- Advance rule, applied on each rising edge with reset=1 and enable=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments in the same edge.
  - v_cnt wraps to 0 from V_TOTAL-1 when h_cnt also wraps.
- Horizontal region order from h_cnt=0: active [0, H_ACTIVE-1], front porch, sync, back porch.
  - Sync region is [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- Vertical regions follow the same order on v_cnt. vsync changes only together with the h_cnt wrap, i.e. it is line-aligned.
- Outputs are registered decodes of the counters: one cycle of latency from counter value to output.
  - All outputs are mutually aligned: x, y, dena, syncs and pulses describe the same pixel in the same cycle.
- Reset (synchronous, reset=0 at an edge):
  - h_cnt = 0, v_cnt = 0.
  - hactive = vactive = dena = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - x = 0, y = 0, line_start = 0, frame_start = 0.
  - Applies mid-line or mid-frame identically; no partial-frame state survives.
- First enabled edge after reset release registers the decode of (0,0):
  - dena = 1, x = 0, y = 0, line_start = 1, frame_start = 1.
  - Counters then advance to (1,0).
- enable = 0:
  - Counters frozen; registered outputs hold their last values.
  - line_start and frame_start are forced to 0 on held cycles, so a pulse never lasts more than one cycle.
- Simultaneous reset=0 and enable=1: reset wins.
- Width rules:
  - x = h_cnt[XW-1:0] when h_cnt < H_ACTIVE, else 0.
  - y likewise against V_ACTIVE.
  - Compares are full-width unsigned; no truncation in the region decode.
- dena is never 1 outside (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).

Test Plan:
Bench params for all scenarios: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), polarities 1; frame = 128 cycles.
1. Release reset, enable=1 → 1st edge: frame_start=1, dena=1, x=0; x counts 0..7; hactive falls at output cycle 8; hsync high in output cycles 10..12 of each line; line_start every 16 cycles.
2. Full frame → vactive high for lines 0..3; vsync high exactly for lines 5..6, rising with the line_start of line 5; frame_start recurs every 128 cycles; dena asserted in exactly 32 cycles per frame.
3. Toggle enable low for 5 cycles mid-line at x=4 → outputs hold x=4 with no extra line_start; resume continues at x=5; frame period becomes 133 cycles.
4. Assert reset for 1 cycle at line 6, h=11 → next cycle all outputs at reset values; after release the frame restarts at (0,0) with frame_start=1.
5. Rebuild with HSYNC_POL=0, VSYNC_POL=0 → reset levels high; hsync and vsync are the exact inverse of scenario 2 waveforms.
6. Default 1080p params, run 2 frames → frame_start spacing = 2200×1125 = 2,475,000 cycles; dena count per frame = 2,073,600.
